// File: rtl/mult_operand_driver.sv
// rtl/mult_operand_driver.sv - loads an operand pair into the sequential multiplier, starts it and returns the product
// Optional watchdog: define MULT_DRV_TIMEOUT_EN to abort stalled handshakes after TIMEOUT cycles.
module mult_operand_driver #(
    parameter int WORD_LENGTH = 5,
    parameter int TIMEOUT     = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req,
    input  logic [WORD_LENGTH-1:0]     A,
    input  logic [WORD_LENGTH-1:0]     B,
    output logic                       busy,
    output logic                       done,
    output logic [2*WORD_LENGTH-1:0]   Product,
    output logic                       err,
    output logic                       load,
    output logic                       op,
    output logic [WORD_LENGTH-1:0]     Data,
    output logic                       start,
    input  logic                       stored,
    input  logic                       ready,
    input  logic [2*WORD_LENGTH-1:0]   Result
);

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, START, WAIT_BUSY, WAIT_DONE, DONE
    } state_t;

    state_t                 state;
    logic [WORD_LENGTH-1:0] b_q;
    logic                   armed;
    logic                   timed_out;

`ifdef MULT_DRV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    logic          in_wait;
    logic          advance;

    always_comb begin
        in_wait = 1'b0;
        advance = 1'b0;
        case (state)
            LOAD_A:    begin in_wait = 1'b1; advance = stored;          end
            LOAD_B:    begin in_wait = 1'b1; advance = stored && armed; end
            WAIT_BUSY: begin in_wait = 1'b1; advance = !ready;          end
            WAIT_DONE: begin in_wait = 1'b1; advance = ready;           end
            default:   ;
        endcase
    end

    assign timed_out = in_wait && (wd_cnt == CW'(TIMEOUT - 1));

    // Clearing on every advance makes the count restart on entry to the next wait state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            err <= timed_out;
            if (!in_wait || advance || timed_out)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            load    <= 1'b0;
            op      <= 1'b0;
            start   <= 1'b0;
            Data    <= '0;
            Product <= '0;
            b_q     <= '0;
            armed   <= 1'b0;
        end else begin
            done  <= 1'b0;
            start <= 1'b0;
            if (timed_out) begin
                state   <= DONE;
                load    <= 1'b0;
                done    <= 1'b1;
                Product <= '0;
            end else begin
                case (state)
                    IDLE: if (req) begin
                        state <= LOAD_A;
                        busy  <= 1'b1;
                        load  <= 1'b1;
                        op    <= 1'b0;
                        Data  <= A;
                        b_q   <= B;
                    end
                    LOAD_A: if (stored) begin
                        state <= LOAD_B;
                        op    <= 1'b1;
                        Data  <= b_q;
                        armed <= 1'b0;
                    end
                    // The first edge in LOAD_B may still see operand A's acknowledge.
                    LOAD_B: begin
                        armed <= 1'b1;
                        if (stored && armed) begin
                            state <= START;
                            load  <= 1'b0;
                            start <= 1'b1;
                        end
                    end
                    START:     state <= WAIT_BUSY;
                    WAIT_BUSY: if (!ready) state <= WAIT_DONE;
                    WAIT_DONE: if (ready) begin
                        state   <= DONE;
                        Product <= Result;
                        done    <= 1'b1;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_operand_driver.sv
// tb/tb_mult_operand_driver.sv - self-checking bench for mult_operand_driver with a behavioural multiplier
module tb_mult_operand_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [4:0] A = '0;
    logic [4:0] B = '0;
    logic       busy, done, err, load, op, start;
    logic [9:0] Product;
    logic [4:0] Data;
    logic       stored = 1'b0;
    logic       ready = 1'b1;
    logic [9:0] Result = '0;

    always #5 clk = ~clk;

    mult_operand_driver #(.WORD_LENGTH(5), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .A(A), .B(B),
        .busy(busy), .done(done), .Product(Product), .err(err),
        .load(load), .op(op), .Data(Data), .start(start),
        .stored(stored), .ready(ready), .Result(Result)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] ref_prod(input logic [4:0] a, input logic [4:0] b);
        int sa, sb, p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        p = sa * sb;
        return p[9:0];
    endfunction

    // Behavioural multiplier: acknowledges each operand after st_delay cycles of load,
    // computes for comp_c cycles after start.
    int   st_delay = 1;
    int   comp_c = 5;
    bit   stuck = 0;
    bit   hold_mode = 0;
    int   ack_cnt, acked_op, comp_cnt;
    logic [4:0] ma, mb;

    always @(posedge clk) begin
        if (reset) begin
            stored   <= 1'b0;
            ready    <= 1'b1;
            Result   <= '0;
            ack_cnt  = 0;
            acked_op = -1;
            comp_cnt = 0;
        end else begin
            if (load) begin
                if (op) mb = Data; else ma = Data;
            end
            if (!load) begin
                acked_op = -1;
                ack_cnt  = 0;
                stored  <= 1'b0;
            end else if (hold_mode && acked_op >= 0) begin
                stored <= 1'b1;
            end else if (int'(op) != acked_op) begin
                if (ack_cnt >= st_delay - 1) begin
                    stored  <= 1'b1;
                    acked_op = int'(op);
                    ack_cnt  = 0;
                end else begin
                    ack_cnt++;
                    stored <= 1'b0;
                end
            end else begin
                stored <= 1'b0;
            end
            if (start && !stuck) begin
                ready   <= 1'b0;
                comp_cnt = comp_c;
            end else if (comp_cnt > 0) begin
                comp_cnt--;
                if (comp_cnt == 0) begin
                    ready  <= 1'b1;
                    Result <= ref_prod(ma, mb);
                end
            end
        end
    end

    int cyc = 0, n_start = 0, n_done = 0, overlap = 0, unstable = 0, la = 0, lb = 0;
    int start_cyc = 0, done_cyc = 0;
    logic       prev_load = 0, prev_op = 0;
    logic [4:0] prev_data = 0, first_b = 0;

    always @(negedge clk) begin
        cyc++;
        if (load && start) overlap++;
        if (start) begin n_start++; start_cyc = cyc; end
        if (done) begin n_done++; done_cyc = cyc; end
        if (load && op && lb == 0) first_b = Data;
        if (load && !op) la++;
        if (load && op) lb++;
        if (load && prev_load && prev_op == op && Data != prev_data) unstable++;
        prev_load = load;
        prev_op   = op;
        prev_data = Data;
    end

    task automatic clear_mon();
        n_start = 0; n_done = 0; overlap = 0; unstable = 0; la = 0; lb = 0;
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b);
        @(posedge clk);
        clear_mon();
        @(negedge clk);
        A = a; B = b; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("issue_busy", busy, 1);
        check("issue_load", load, 1);
        check("issue_op", op, 0);
        check("issue_data", Data, a);
    endtask

    task automatic finish_txn(input string nm, input logic [9:0] exp_p);
        for (int k = 0; k < 300 && !done; k++) @(negedge clk);
        check({nm, "_done_seen"}, done, 1);
        check({nm, "_product"}, Product, exp_p);
        check({nm, "_err"}, err, 0);
        check({nm, "_one_start"}, n_start, 1);
        check({nm, "_no_overlap"}, overlap, 0);
        check({nm, "_data_stable"}, unstable, 0);
        @(negedge clk);
        check({nm, "_done_width"}, {done, busy, load}, 3'b000);
        check({nm, "_one_done"}, n_done, 1);
    endtask

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        int         d;
        int         c;
        logic [9:0] p;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{5'b10011, 5'd11, 1, 5, 10'h371};
        vecs[1] = '{5'd3, 5'b11110, 2, 3, 10'h3FA};
        vecs[2] = '{5'd0, 5'b10000, 1, 1, 10'h000};
        vecs[3] = '{5'b10000, 5'b10000, 3, 7, 10'h100};
        vecs[4] = '{5'd15, 5'd15, 1, 2, 10'h0E1};
        vecs[5] = '{5'd15, 5'b10000, 2, 4, 10'h310};

        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy, done, err, load, op, start}, 6'b0);
        check("rst_data", Data, 0);
        check("rst_product", Product, 0);
        reset = 1'b0;

        // Canonical transaction: -13 * 11
        st_delay = 1; comp_c = 5;
        issue(5'b10011, 5'd11);
        for (int k = 0; k < 50 && !start; k++) @(negedge clk);
        check("t1_first_b", first_b, 5'h0B);
        check("t1_b_loaded", lb > 0, 1);
        finish_txn("t1", 10'h371);

        foreach (vecs[i]) begin
            st_delay = vecs[i].d; comp_c = vecs[i].c;
            issue(vecs[i].a, vecs[i].b);
            finish_txn($sformatf("vec%0d", i), vecs[i].p);
        end

        // Slow acknowledge: load held for the whole delay on each operand
        st_delay = 4; comp_c = 3;
        issue(5'd6, 5'b11001);
        finish_txn("slow", ref_prod(5'd6, 5'b11001));
        check("slow_la", la, 5);
        check("slow_lb", lb, 5);

        // Acknowledge held high across the operand switch must not complete B at once
        hold_mode = 1; st_delay = 1; comp_c = 2;
        issue(5'd5, 5'b11101);
        finish_txn("stale", ref_prod(5'd5, 5'b11101));
        check("stale_lb", lb, 2);
        hold_mode = 0;

        // Second req during WAIT_DONE and operand changes after capture
        st_delay = 1; comp_c = 10;
        issue(5'd7, 5'b11011);
        A = 5'd1; B = 5'd1;
        for (int k = 0; k < 50 && !start; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        finish_txn("ignore", ref_prod(5'd7, 5'b11011));
        repeat (30) @(negedge clk);
        check("ignore_no_second", {n_done[7:0], 7'b0, busy}, {8'd1, 8'd0});

        // Reset while loading operand B
        st_delay = 4; comp_c = 3;
        issue(5'd9, 5'd9);
        for (int k = 0; k < 50 && !(load && op); k++) @(negedge clk);
        check("rstmid_in_load_b", {load, op}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_ctrl", {busy, done, err, load, op, start}, 6'b0);
        check("rstmid_data", Data, 0);
        check("rstmid_product", Product, 0);
        @(posedge clk);
        clear_mon();
        repeat (30) @(negedge clk);
        check("rstmid_quiet", {n_start[7:0], n_done[7:0]}, 16'h0);
        st_delay = 1; comp_c = 4;
        issue(5'd3, 5'b11110);
        finish_txn("after_rst", 10'h3FA);

        // Randomised transactions against the arithmetic reference
        for (int i = 0; i < 20; i++) begin
            logic [4:0] ra, rb;
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            st_delay = $urandom_range(1, 4);
            comp_c = $urandom_range(1, 8);
            hold_mode = ($urandom_range(0, 3) == 0);
            issue(ra, rb);
            finish_txn($sformatf("rnd%0d", i), ref_prod(ra, rb));
        end
        hold_mode = 0;

        // Multiplier that never leaves ready
        stuck = 1; st_delay = 1;
        issue(5'd5, 5'd5);
`ifdef MULT_DRV_TIMEOUT_EN
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        check("to_done", done, 1);
        check("to_err", err, 1);
        check("to_product", Product, 0);
        check("to_wait_len", done_cyc - start_cyc, 9);
        @(negedge clk);
        check("to_clear", {done, err, busy}, 3'b000);
`else
        repeat (40) @(negedge clk);
        check("stuck_busy", busy, 1);
        check("stuck_err", err, 0);
        check("stuck_no_done", n_done, 0);
        check("stuck_one_start", n_start, 1);
`endif
        stuck = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
